// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
//   divState_e    : FSM state encoding
//   DIV_WIDTH     : default operand width
//   COUNT_W       : width of the step counter (indexes 0..DIV_WIDTH-1)
//   DIV_BY_ZERO_Q : quotient returned when the divisor is zero
package div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int COUNT_W   = $clog2(DIV_WIDTH);

   localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } divState_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (purely combinational).
//   rem, quo  : partial remainder / quotient-dividend shift pair
//   divisor   : magnitude of the divisor
//   rem_next  : remainder after shift and trial subtract
//   quo_next  : quotient with the new bit shifted into the LSB
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] remShift;
   logic [WIDTH:0] trial;

   // One extra bit keeps the shifted remainder exact; rem < divisor always
   // holds, so the restored or subtracted value fits back into WIDTH bits.
   assign remShift = {rem, quo[WIDTH-1]};
   assign trial    = remShift - {1'b0, divisor};

   always_comb begin
      if (trial[WIDTH]) begin
         rem_next = remShift[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b0};
      end else begin
         rem_next = trial[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider for the EX stage (DIV/DIVU).
//   clk, rst     : pipeline clock, synchronous active-high reset
//   start        : divide instruction sits in E (held while stalled)
//   signed_div   : 1 = two's complement DIV, 0 = DIVU
//   a, b         : dividend / divisor, sampled only in IDLE
//   annul        : cancel the in-flight division (highest priority)
//   stall_div    : stall request to the hazard unit
//   result       : {remainder, quotient} for the HI/LO write
//   result_valid : one-cycle qualifier for result
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands latched on the launch cycle
// BUSY  | one restoring step per cycle, WIDTH cycles
// DONE  | result_valid for one cycle, stall released, start ignored
module div_iter
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_div,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 annul,
   output logic                 stall_div,
   output logic [2*WIDTH-1:0]   result,
   output logic                 result_valid
);

   divState_e state, stateNext;

   logic [COUNT_W-1:0] count;
   logic [WIDTH-1:0]   remR, quoR, divisorR;
   logic [WIDTH-1:0]   remNext, quoNext;
   logic [WIDTH-1:0]   absA, absB;
   logic               negQ, negR;
   logic               launch, lastStep;

   assign absA     = (signed_div && a[WIDTH-1]) ? -a : a;
   assign absB     = (signed_div && b[WIDTH-1]) ? -b : b;
   assign lastStep = (count == COUNT_W'(WIDTH-1));

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (remR),
      .quo      (quoR),
      .divisor  (divisorR),
      .rem_next (remNext),
      .quo_next (quoNext)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   always_comb begin
      stateNext    = state;
      stall_div    = 1'b0;
      result_valid = 1'b0;
      launch       = 1'b0;
      if (annul) begin
         stateNext = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  stall_div = 1'b1;
                  launch    = 1'b1;
                  stateNext = (b == '0) ? DONE : BUSY;
               end
            end
            BUSY: begin
               stall_div = 1'b1;
               if (lastStep) stateNext = DONE;
            end
            DONE: begin
               result_valid = 1'b1;
               stateNext    = IDLE;
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count    <= '0;
         result   <= '0;
         remR     <= '0;
         quoR     <= '0;
         divisorR <= '0;
         negQ     <= 1'b0;
         negR     <= 1'b0;
      end else if (annul) begin
         count <= '0;
      end else begin
         case (state)
            IDLE: begin
               count <= '0;
               if (launch) begin
                  remR     <= '0;
                  quoR     <= absA;
                  divisorR <= absB;
                  negQ     <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                  negR     <= signed_div & a[WIDTH-1];
                  // Divide by zero skips BUSY: remainder is the raw dividend.
                  if (b == '0) result <= {a, DIV_BY_ZERO_Q};
               end
            end
            BUSY: begin
               remR  <= remNext;
               quoR  <= quoNext;
               count <= count + 1'b1;
               // Sign fixup folded into the final step so result is ready in DONE.
               if (lastStep)
                  result <= {(negR ? -remNext : remNext), (negQ ? -quoNext : quoNext)};
            end
            default: count <= '0;
         endcase
      end
   end

endmodule
